// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access path.
// Load/store type codes match the EX/MEM register fields.
package mips_mem_pkg;

   typedef enum logic [3:0] {
      LT_NONE = 4'd0,
      LT_LB   = 4'd1,
      LT_LBU  = 4'd2,
      LT_LH   = 4'd3,
      LT_LHU  = 4'd4,
      LT_LW   = 4'd5
   } load_type_e;

   typedef enum logic [2:0] {
      ST_NONE = 3'd0,
      ST_SB   = 3'd1,
      ST_SH   = 3'd2,
      ST_SW   = 3'd3
   } save_type_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data memory: store enables/replication, alignment
// check and load extraction with sign/zero extension.
module mem_lane_align
   import mips_mem_pkg::*;
#(
   parameter int BIG_ENDIAN = 0
) (
   input  logic [1:0]  addr_lo,
   input  logic        is_write,
   input  logic [3:0]  load_type,
   input  logic [2:0]  save_type,
   input  logic [31:0] wr_data,
   input  logic [31:0] rd_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misaligned,
   output logic [31:0] load_ext
);

   logic [1:0]  lane;
   logic        half_hi;
   logic        is_byte;
   logic        is_half;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Big-endian mirrors the lane number; half_hi selects bits [31:16].
   assign lane    = (BIG_ENDIAN != 0) ? ~addr_lo : addr_lo;
   assign half_hi = (BIG_ENDIAN != 0) ? ~addr_lo[1] : addr_lo[1];

   always_comb begin
      is_byte = 1'b0;
      is_half = 1'b0;
      if (is_write) begin
         case (save_type)
            ST_SB:   is_byte = 1'b1;
            ST_SH:   is_half = 1'b1;
            default: ;
         endcase
      end else begin
         case (load_type)
            LT_LB, LT_LBU: is_byte = 1'b1;
            LT_LH, LT_LHU: is_half = 1'b1;
            default:       ;
         endcase
      end
   end

   assign misaligned = is_half ? addr_lo[0] : (!is_byte && (addr_lo != 2'b00));

   always_comb begin
      be    = 4'b1111;
      wdata = wr_data;
      if (is_write) begin
         if (is_byte) begin
            be    = 4'b0001 << lane;
            wdata = {4{wr_data[7:0]}};
         end else if (is_half) begin
            be    = half_hi ? 4'b1100 : 4'b0011;
            wdata = {2{wr_data[15:0]}};
         end
      end
   end

   assign rd_byte = rd_data[{lane, 3'b000} +: 8];
   assign rd_half = half_hi ? rd_data[31:16] : rd_data[15:0];

   always_comb begin
      case (load_type)
         LT_LB:   load_ext = sext8(rd_byte);
         LT_LBU:  load_ext = {24'h0, rd_byte};
         LT_LH:   load_ext = sext16(rd_half);
         LT_LHU:  load_ext = {16'h0, rd_half};
         default: load_ext = rd_data;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns the EX/MEM access into a req/ack
// transaction, stalls the pipeline while it is outstanding.
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8,
   parameter int BIG_ENDIAN     = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic [3:0]  load_type,
   input  logic [2:0]  save_type,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_stall,
   output logic [31:0] load_data,
   output logic        addr_exc,
   output logic        bus_err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     waddr_q, waddr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     load_data_q, load_data_d;
   logic [1:0]      lo_q, lo_d;
   logic [3:0]      lt_q, lt_d;
   logic            addr_exc_q, addr_exc_d;
   logic            bus_err_q, bus_err_d;

   logic        op;
   logic        busy;
   logic [1:0]  al_lo;
   logic        al_we;
   logic [3:0]  al_lt;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic        al_mis;
   logic [31:0] al_ext;

   assign op   = mem_read | mem_write;
   assign busy = (state_q == S_BUSY);

   // In IDLE the aligner sees the live request; in BUSY it sees the latched
   // access so load extraction uses the captured address and type.
   assign al_lo = busy ? lo_q : addr[1:0];
   assign al_we = busy ? we_q : mem_write;
   assign al_lt = busy ? lt_q : load_type;

   mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .addr_lo    (al_lo),
      .is_write   (al_we),
      .load_type  (al_lt),
      .save_type  (save_type),
      .wr_data    (write_data),
      .rd_data    (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .misaligned (al_mis),
      .load_ext   (al_ext)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      be_d        = be_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      load_data_d = load_data_q;
      lo_d        = lo_q;
      lt_d        = lt_q;
      addr_exc_d  = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (op) begin
               if (al_mis) begin
                  addr_exc_d = 1'b1;
               end else begin
                  we_d    = mem_write;
                  be_d    = al_be;
                  waddr_d = {addr[31:2], 2'b00};
                  wdata_d = al_wdata;
                  lo_d    = addr[1:0];
                  lt_d    = load_type;
                  cnt_d   = '0;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            // Ack in the final counted cycle still completes cleanly.
            if (dmem_ack) begin
               if (!we_q) load_data_d = al_ext;
               state_d = S_DONE;
            end else if (cnt_q == TO_LAST) begin
               if (!we_q) load_data_d = '0;
               bus_err_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         load_data_q <= '0;
         lo_q        <= '0;
         lt_q        <= '0;
         addr_exc_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         be_q        <= be_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         load_data_q <= load_data_d;
         lo_q        <= lo_d;
         lt_q        <= lt_d;
         addr_exc_q  <= addr_exc_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign dmem_req   = busy;
   assign dmem_we    = we_q;
   assign dmem_addr  = waddr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;
   assign load_data  = load_data_q;
   assign addr_exc   = addr_exc_q;
   assign bus_err    = bus_err_q;
   assign mem_stall  = ((state_q == S_IDLE) && op && !al_mis) || busy;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected transactions,
// a monitor process compares them as the DUT presents requests/completions.
module tb_mem_access_unit;
   import mips_mem_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic [3:0]  load_type = '0;
   logic [2:0]  save_type = '0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic        mem_stall;
   logic [31:0] load_data;
   logic        addr_exc;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(TO), .TO_W(8), .BIG_ENDIAN(0)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .write_data(write_data), .load_type(load_type), .save_type(save_type),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .mem_stall(mem_stall), .load_data(load_data), .addr_exc(addr_exc), .bus_err(bus_err)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
      logic        berr;
      int          nbusy;
      logic        abort;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exc_q[$];
   int          total = 0;
   int          bad = 0;
   int          ack_at = 0;
   logic [31:0] rd_val = '0;
   logic        stray = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic exp_t mk(input logic we, input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] ld, input logic berr,
                               input int nb, input logic ab);
      exp_t e;
      e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.ld = ld;
      e.berr = berr; e.nbusy = nb; e.abort = ab;
      return e;
   endfunction

   // Memory model: ack in the ack_at-th BUSY cycle (0 = never).
   int busy_n = 0;
   always @(negedge clk) begin
      dmem_ack = 1'b0;
      if (!rst_n || !dmem_req) begin
         busy_n = 0;
      end else begin
         busy_n++;
         if (busy_n == ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rd_val;
         end
      end
      if (stray) begin
         dmem_ack   = 1'b1;
         dmem_rdata = 32'hFFFF_FFFF;
      end
   end

   // Monitor
   logic req_prev = 1'b0;
   int   stall_cnt = 0;
   int   bcnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         if (exp_q.size() > 0 && exp_q[0].abort) void'(exp_q.pop_front());
         req_prev  = 1'b0;
         stall_cnt = 0;
         bcnt      = 0;
      end else begin
         if (dmem_req && !req_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", 32'd1, 32'd0);
            end else begin
               chk("req_addr", dmem_addr, exp_q[0].addr);
               chk("req_we", 32'(dmem_we), 32'(exp_q[0].we));
               chk("req_be", 32'(dmem_be), 32'(exp_q[0].be));
               if (exp_q[0].we) chk("req_wdata", dmem_wdata, exp_q[0].wdata);
            end
         end
         if (req_prev && !dmem_req) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("done_load_data", load_data, e.ld);
               chk("done_bus_err", 32'(bus_err), 32'(e.berr));
               chk("done_busy_cycles", 32'(bcnt), 32'(e.nbusy));
               chk("done_stall_cycles", 32'(stall_cnt), 32'(e.nbusy + 1));
               chk("done_stall_low", 32'(mem_stall), 32'd0);
            end
            stall_cnt = 0;
            bcnt      = 0;
         end else if (bus_err) begin
            chk("stray_bus_err", 32'd1, 32'd0);
         end
         if (addr_exc) begin
            if (exc_q.size() == 0) begin
               chk("unexpected_addr_exc", 32'd1, 32'd0);
            end else begin
               chk("exc_load_data", load_data, exc_q.pop_front());
               chk("exc_no_req", 32'(dmem_req), 32'd0);
            end
         end
         if (dmem_req) bcnt++;
         if (mem_stall) stall_cnt++;
         req_prev = dmem_req;
      end
   end

   task automatic drive(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] lt, input logic [2:0] st);
      mem_read = mr; mem_write = mw; addr = a; write_data = wd;
      load_type = lt; save_type = st;
   endtask

   task automatic idle_in();
      mem_read = 1'b0; mem_write = 1'b0; load_type = '0; save_type = '0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_stall && n < 40);
      if (mem_stall) chk({nm, "_stall_bound"}, 32'd1, 32'd0);
      @(posedge clk); #1;
      idle_in();
      @(posedge clk); #1;
   endtask

   task automatic access(input string nm, input logic mr, input logic mw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] lt, input logic [2:0] st,
                         input int ack, input logic [31:0] rd, input exp_t e);
      ack_at = ack;
      rd_val = rd;
      exp_q.push_back(e);
      drive(mr, mw, a, wd, lt, st);
      wait_done(nm);
   endtask

   task automatic misalign(input logic mr, input logic mw, input logic [31:0] a,
                           input logic [3:0] lt, input logic [2:0] st, input logic [31:0] ld);
      exc_q.push_back(ld);
      drive(mr, mw, a, 32'h0, lt, st);
      @(posedge clk); #1;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_ctrl", 32'({dmem_req, dmem_we, dmem_be, addr_exc, bus_err, mem_stall}), 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      access("sw", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, LT_NONE, ST_SW, 1, 32'h0,
             mk(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b0));
      access("lb", 1'b1, 1'b0, 32'h203, 32'h0, LT_LB, ST_NONE, 2, 32'h80112233,
             mk(1'b0, 32'h200, 4'hF, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0));
      access("lbu", 1'b1, 1'b0, 32'h203, 32'h0, LT_LBU, ST_NONE, 1, 32'h80112233,
             mk(1'b0, 32'h200, 4'hF, 32'h0, 32'h00000080, 1'b0, 1, 1'b0));
      access("sh", 1'b0, 1'b1, 32'h302, 32'h0000ABCD, LT_NONE, ST_SH, 1, 32'h0,
             mk(1'b1, 32'h300, 4'hC, 32'hABCDABCD, 32'h00000080, 1'b0, 1, 1'b0));
      access("lhu", 1'b1, 1'b0, 32'h302, 32'h0, LT_LHU, ST_NONE, 3, 32'hABCD1234,
             mk(1'b0, 32'h300, 4'hF, 32'h0, 32'h0000ABCD, 1'b0, 3, 1'b0));
      access("lh", 1'b1, 1'b0, 32'h300, 32'h0, LT_LH, ST_NONE, 1, 32'h1234F00D,
             mk(1'b0, 32'h300, 4'hF, 32'h0, 32'hFFFFF00D, 1'b0, 1, 1'b0));
      access("sb", 1'b0, 1'b1, 32'h101, 32'h12345678, LT_NONE, ST_SB, 1, 32'h0,
             mk(1'b1, 32'h100, 4'h2, 32'h78787878, 32'hFFFFF00D, 1'b0, 1, 1'b0));
      access("lw", 1'b1, 1'b0, 32'h400, 32'h0, LT_LW, ST_NONE, 1, 32'hCAFEBABE,
             mk(1'b0, 32'h400, 4'hF, 32'h0, 32'hCAFEBABE, 1'b0, 1, 1'b0));
      access("rw_both", 1'b1, 1'b1, 32'h500, 32'h01020304, LT_LW, ST_SW, 1, 32'h55555555,
             mk(1'b1, 32'h500, 4'hF, 32'h01020304, 32'hCAFEBABE, 1'b0, 1, 1'b0));

      misalign(1'b1, 1'b0, 32'h401, LT_LW, ST_NONE, 32'hCAFEBABE);
      misalign(1'b0, 1'b1, 32'h303, LT_NONE, ST_SH, 32'hCAFEBABE);
      misalign(1'b1, 1'b0, 32'h301, LT_LH, ST_NONE, 32'hCAFEBABE);

      stray = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      stray = 1'b0;
      @(posedge clk); #1;
      chk("stray_ack_load_data", load_data, 32'hCAFEBABE);

      access("lw_timeout", 1'b1, 1'b0, 32'h600, 32'h0, LT_LW, ST_NONE, 0, 32'h0,
             mk(1'b0, 32'h600, 4'hF, 32'h0, 32'h0, 1'b1, TO, 1'b0));
      access("lw_ack_last", 1'b1, 1'b0, 32'h604, 32'h0, LT_LW, ST_NONE, TO, 32'h11112222,
             mk(1'b0, 32'h604, 4'hF, 32'h0, 32'h11112222, 1'b0, TO, 1'b0));

      ack_at = 0;
      exp_q.push_back(mk(1'b0, 32'h700, 4'hF, 32'h0, 32'h0, 1'b0, 0, 1'b1));
      drive(1'b1, 1'b0, 32'h700, 32'h0, LT_LW, ST_NONE);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_req", 32'(dmem_req), 32'd0);
      chk("async_rst_pulses", 32'({addr_exc, bus_err}), 32'd0);
      chk("async_rst_load_data", load_data, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      ack_at = 1;
      rd_val = 32'h0BADF00D;
      exp_q.push_back(mk(1'b0, 32'h700, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 1, 1'b0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_done("post_rst_lw");

      repeat (3) @(posedge clk);
      #1;
      chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("exc_queue_drained", 32'(exc_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
